// File: rtl/uart_rx_frame_counter_if.sv
// Control and status bundle between the RX FSM/sampler and the frame counter.
// master drives enable and the frame configuration; slave is the counter itself.
interface uart_rx_frame_counter_if #(
    parameter int PRESCALE_W = 6
);
    logic                  enable;
    logic [PRESCALE_W-1:0] prescale;
    logic [3:0]            data_len;
    logic                  PAR_EN;
    logic                  stop_bits;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic [1:0]            phase;
    logic [3:0]            data_idx;
    logic                  sample_stb;
    logic                  bit_done;
    logic                  frame_done;

    modport master (
        output enable, prescale, data_len, PAR_EN, stop_bits,
        input  edge_cnt, bit_cnt, phase, data_idx, sample_stb, bit_done, frame_done
    );

    modport slave (
        input  enable, prescale, data_len, PAR_EN, stop_bits,
        output edge_cnt, bit_cnt, phase, data_idx, sample_stb, bit_done, frame_done
    );
endinterface

// File: rtl/uart_rx_frame_counter.sv
// UART RX edge/bit/frame counter with runtime oversampling ratio and decoded strobes.
// Optional feature macro: UART_RX_CNT_STOP2_EN (honour stop_bits for two stop bits).
module uart_rx_frame_counter #(
    parameter int PRESCALE_W    = 6,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                  clk,
    input  logic                  ARST,
    uart_rx_frame_counter_if.slave bus
);
    localparam logic [1:0] PH_START  = 2'd0;
    localparam logic [1:0] PH_DATA   = 2'd1;
    localparam logic [1:0] PH_PARITY = 2'd2;
    localparam logic [1:0] PH_STOP   = 2'd3;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  active;

    logic [PRESCALE_W-1:0] p_sh;
    logic [3:0]            d_sh;
    logic                  par_sh;
    logic [3:0]            n_sh;

    logic [PRESCALE_W-1:0] p_in;
    logic [3:0]            d_in;
    logic [3:0]            n_in;
    logic                  stop2;

`ifdef UART_RX_CNT_STOP2_EN
    assign stop2 = bus.stop_bits;
`else
    logic stop_bits_unused;
    assign stop_bits_unused = bus.stop_bits;
    assign stop2            = 1'b0;
`endif

    always_comb begin
        p_in = (bus.prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : bus.prescale;
        if (bus.data_len < 4'd5)
            d_in = 4'd5;
        else if (bus.data_len > 4'(MAX_DATA_BITS))
            d_in = 4'(MAX_DATA_BITS);
        else
            d_in = bus.data_len;
        // start + data + parity + first stop, plus the optional second stop
        n_in = 4'd2 + d_in + {3'b000, bus.PAR_EN} + {3'b000, stop2};
    end

    logic [PRESCALE_W-1:0] mid;
    logic                  last_edge;
    logic                  last_bit;

    assign mid       = p_sh >> 1;
    assign last_edge = (edge_cnt == p_sh - PRESCALE_W'(1));
    assign last_bit  = (bit_cnt == n_sh - 4'd1);

    always_ff @(posedge clk or posedge ARST) begin
        if (ARST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
            p_sh     <= PRESCALE_W'(4);
            d_sh     <= 4'd5;
            par_sh   <= 1'b0;
            n_sh     <= 4'd7;
        end else if (!bus.enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            active   <= 1'b0;
        end else begin
            active <= 1'b1;
            // Config is sampled only at frame boundaries so a frame never changes shape mid-flight.
            if (!active || (last_edge && last_bit)) begin
                p_sh   <= p_in;
                d_sh   <= d_in;
                par_sh <= bus.PAR_EN;
                n_sh   <= n_in;
            end
            if (last_edge) begin
                edge_cnt <= '0;
                bit_cnt  <= last_bit ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

    always_comb begin
        bus.phase    = PH_STOP;
        bus.data_idx = 4'd0;
        if (bit_cnt == 4'd0) begin
            bus.phase = PH_START;
        end else if (bit_cnt <= d_sh) begin
            bus.phase    = PH_DATA;
            bus.data_idx = bit_cnt - 4'd1;
        end else if (par_sh && (bit_cnt == d_sh + 4'd1)) begin
            bus.phase = PH_PARITY;
        end
    end

    assign bus.edge_cnt   = edge_cnt;
    assign bus.bit_cnt    = bit_cnt;
    assign bus.sample_stb = bus.enable && ((edge_cnt == mid - PRESCALE_W'(1)) ||
                                           (edge_cnt == mid) ||
                                           (edge_cnt == mid + PRESCALE_W'(1)));
    assign bus.bit_done   = bus.enable && last_edge;
    assign bus.frame_done = bus.enable && last_edge && last_bit;
endmodule
